orf_result_drain: RTL and testbench

//  Reader side of the MVU output register file (ORF). On the MVU done pulse, reads a

---
 rtl/orf_result_drain_pkg.sv | 10 +
 rtl/orf_result_drain_fifo.sv | 48 ++++
 rtl/orf_result_drain.sv | 117 +++++++++++
 tb/tb_orf_result_drain.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/orf_result_drain_pkg.sv
// orf_result_drain_pkg: shared ORF geometry defaults and drain FSM state encoding.
package orf_result_drain_pkg;
    localparam int ORF_DWIDTH = 32;
    localparam int ORF_AWIDTH = 4;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_FLUSH
    } drain_state_e;
endpackage

// File: rtl/orf_result_drain_fifo.sv
// orf_result_drain_fifo: synchronous FIFO of result words with a last tag; occupancy
// is exported so the reader can issue ORF reads only against free credit.
module orf_result_drain_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic                     i_last,
    input  logic                     i_pop,
    output logic [DWIDTH-1:0]        o_data,
    output logic                     o_last,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DWIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_last;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;
    assign w_pop   = i_pop & (r_count != '0);
    assign o_data  = r_data[r_rptr];
    assign o_last  = r_last[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
            r_last  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_data[r_wptr] <= i_data;
                r_last[r_wptr] <= i_last;
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/orf_result_drain.sv
// orf_result_drain: on MVU done, reads a run of ORF words (1-cycle latency) into a small
// FIFO and streams them out with a last marker. ORF_DRAIN_STALL_CNT_EN adds o_stall_cnt.
module orf_result_drain
    import orf_result_drain_pkg::*;
#(
    parameter int DWIDTH     = ORF_DWIDTH,
    parameter int AWIDTH     = ORF_AWIDTH,
    parameter int CWIDTH     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_done,
    input  logic [AWIDTH-1:0] i_base_addr,
    input  logic [CWIDTH-1:0] i_num_words,
    output logic              o_orf_rd_en,
    output logic [AWIDTH-1:0] o_orf_rd_addr,
    input  logic [DWIDTH-1:0] i_orf_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DWIDTH-1:0] o_out_data,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_drain_done,
    output logic              o_err_overrun
`ifdef ORF_DRAIN_STALL_CNT_EN
    ,
    output logic [15:0]       o_stall_cnt
`endif
);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    drain_state_e      r_state;
    drain_state_e      w_state_nxt;
    logic [AWIDTH-1:0] r_addr;
    logic [CWIDTH-1:0] r_remain;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_drain_done;
    logic              r_err;
    logic              w_accept;
    logic              w_credit;
    logic              w_rd_en;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_last;
    logic [CNTW-1:0]   w_fifo_count;
    assign w_accept      = (r_state == ST_IDLE) & i_done;
    // A read in flight already owns a FIFO slot, so it counts against credit.
    assign w_credit      = (w_fifo_count + CNTW'(r_inflight)) < CNTW'(FIFO_DEPTH);
    assign w_rd_en       = (r_state == ST_READ) & w_credit;
    assign w_pop         = o_out_valid & i_out_ready;
    assign o_orf_rd_en   = w_rd_en;
    assign o_orf_rd_addr = r_addr;
    assign o_out_valid   = ~w_fifo_empty;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_drain_done  = r_drain_done;
    assign o_err_overrun = r_err;
    always_ff @(posedge clk) begin
        r_state <= rst ? ST_IDLE : w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = (i_done && i_num_words != '0) ? ST_READ : ST_IDLE;
            ST_READ:  w_state_nxt = (w_credit && r_remain == CWIDTH'(1)) ? ST_FLUSH : ST_READ;
            ST_FLUSH: w_state_nxt = (w_pop && w_fifo_last) ? ST_IDLE : ST_FLUSH;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_drain_done    <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr   <= i_base_addr;
                r_remain <= i_num_words;
            end else if (w_rd_en) begin
                r_addr   <= r_addr + AWIDTH'(1);
                r_remain <= r_remain - CWIDTH'(1);
            end
            r_inflight      <= w_rd_en;
            r_inflight_last <= w_rd_en & (r_remain == CWIDTH'(1));
            r_drain_done    <= (w_accept & (i_num_words == '0))
                             | ((r_state == ST_FLUSH) & w_pop & w_fifo_last);
            r_err           <= r_err | (i_done & (r_state != ST_IDLE));
        end
    end
    orf_result_drain_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_drain_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (i_orf_rd_data),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_data  (o_out_data),
        .o_last  (w_fifo_last),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );
    assign o_out_last = w_fifo_last & ~w_fifo_empty;
`ifdef ORF_DRAIN_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    assign o_stall_cnt = r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst || w_accept) r_stall_cnt <= '0;
        else if (o_out_valid && !i_out_ready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_orf_result_drain.sv
// tb_orf_result_drain: randomized and directed drains checked against a queue-based
// model of the ORF contents, read addresses and expected output stream.
module tb_orf_result_drain;
    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } word_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  num_words = '0;
    logic        orf_rd_en;
    logic [3:0]  orf_rd_addr;
    logic [31:0] orf_rd_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        drain_done;
    logic        err_overrun;
`ifdef ORF_DRAIN_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    always #5 clk = ~clk;
    orf_result_drain dut (
        .clk           (clk),
        .rst           (rst),
        .i_done        (done),
        .i_base_addr   (base_addr),
        .i_num_words   (num_words),
        .o_orf_rd_en   (orf_rd_en),
        .o_orf_rd_addr (orf_rd_addr),
        .i_orf_rd_data (orf_rd_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_last    (out_last),
        .o_busy        (busy),
        .o_drain_done  (drain_done),
        .o_err_overrun (err_overrun)
`ifdef ORF_DRAIN_STALL_CNT_EN
        ,
        .o_stall_cnt   (stall_cnt)
`endif
    );
    int n_checks = 0;
    int n_errors = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    logic [31:0] orf [16];
    word_t       exp_q [$];
    logic [3:0]  addr_q [$];
    bit          m_busy = 0;
    bit          m_err = 0;
    int          cyc = 0;
    int          t_done = 0;
    int          first_rd = -1;
    int          first_valid = -1;
    int          drain_cyc = -1;
    int          run_rd = 0;
    int          run_pop = 0;
    int          rd_tot = 0;
    int          pop_tot = 0;
    int          stall_model = 0;
    bit          prev_stall = 0;
    word_t       prev_w;
    int          rdy_mode = 0;
    int          rdy_pct = 100;
    int          rdy_until = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // ORF read port: data valid one cycle after the strobe, garbage otherwise.
    always @(posedge clk) orf_rd_data <= orf_rd_en ? orf[orf_rd_addr] : 32'($urandom);
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? ($urandom_range(0, 99) < rdy_pct) : (cyc >= rdy_until);
        end
    end
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_word", {out_data, out_last}, prev_w);
            end
            if (orf_rd_en) begin
                rd_tot++;
                run_rd++;
                if (first_rd < 0) first_rd = cyc;
                if (addr_q.size() > 0) check("rd_addr", orf_rd_addr, addr_q.pop_front());
                else check("extra_rd", 1, 0);
                check("credit", (rd_tot - pop_tot) <= 4, 1);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                pop_tot++;
                run_pop++;
                if (exp_q.size() > 0) begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("out_data", out_data, w.d);
                    check("out_last", out_last, w.l);
                    if (w.l) m_busy = 0;
                end else check("extra_word", 1, 0);
            end
            if (out_valid && !out_ready) stall_model++;
            if (drain_done && drain_cyc < 0) drain_cyc = cyc;
            prev_stall = out_valid && !out_ready;
            prev_w = {out_data, out_last};
        end
    end
    task automatic start(input int b, input int n);
        @(posedge clk);
        #1;
        done = 1'b1;
        base_addr = b[3:0];
        num_words = n[4:0];
        if (m_busy) m_err = 1;
        else begin
            t_done = cyc;
            first_rd = -1;
            first_valid = -1;
            drain_cyc = -1;
            run_rd = 0;
            run_pop = 0;
            stall_model = 0;
            for (int i = 0; i < n; i++) begin
                addr_q.push_back(4'((b + i) % 16));
                exp_q.push_back({orf[(b + i) % 16], i == n - 1});
            end
            m_busy = (n > 0);
        end
        @(posedge clk);
        #1;
        done = 1'b0;
        base_addr = 4'($urandom);
        num_words = 5'($urandom);
    endtask
    task automatic wait_drain(input int limit);
        int k = 0;
        while (drain_cyc < 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check("drain_seen", drain_cyc >= 0, 1);
        @(negedge clk);
        check("busy_end", busy, 0);
        check("queue_left", exp_q.size(), 0);
`ifdef ORF_DRAIN_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 64'(stall_model));
`endif
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, orf_rd_en, 0);
        check({tag, "_rd_addr"}, orf_rd_addr, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drain_done"}, drain_done, 0);
        check({tag, "_err"}, err_overrun, 0);
    endtask
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 16; i++) orf[i] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        // 1: basic run, latency and completion timing
        rdy_mode = 0;
        start(0, 4);
        wait_drain(50);
        check("first_rd_lat", first_rd - t_done, 1);
        check("first_valid_lat", first_valid - t_done, 3);
        check("drain_lat", drain_cyc - t_done, 7);
        check("t1_pops", run_pop, 4);
        // 2: address wrap
        start(14, 4);
        wait_drain(50);
        check("t2_pops", run_pop, 4);
        check("t2_reads", run_rd, 4);
        // 3: backpressure limits reads to FIFO credit
        rdy_mode = 2;
        rdy_until = cyc + 12;
        start(2, 8);
        repeat (9) @(negedge clk);
        check("t3_reads_stalled", run_rd, 4);
        check("t3_pops_stalled", run_pop, 0);
        wait_drain(100);
        check("t3_pops", run_pop, 8);
        rdy_mode = 0;
        // 4: done while busy is flagged and ignored
        start(7, 6);
        start(3, 2);
        wait_drain(100);
        check("t4_err", err_overrun, 1);
        check("t4_pops", run_pop, 6);
        repeat (20) @(negedge clk);
        check("t4_no_second_run", run_rd, 6);
        // 5: empty run
        start(9, 0);
        wait_drain(20);
        check("t5_drain_lat", drain_cyc - t_done, 1);
        check("t5_no_reads", run_rd, 0);
        check("t5_no_valid", first_valid, -1);
        // 6: reset mid-run, then a fresh drain
        start(0, 8);
        begin
            int k = 0;
            while (run_pop < 2 && k < 50) begin
                @(posedge clk);
                k++;
            end
            check("t6_reach_two", run_pop, 2);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        m_busy = 0;
        m_err = 0;
        rd_tot = 0;
        pop_tot = 0;
        @(negedge clk);
        check_idle_outputs("t6_after_rst");
        start(5, 2);
        wait_drain(50);
        check("t6_pops", run_pop, 2);
        check("t6_err", err_overrun, 0);
        // randomized runs, occasional overlapping done
        for (int it = 0; it < 40; it++) begin
            int n;
            rdy_mode = $urandom_range(0, 1);
            rdy_pct = $urandom_range(20, 100);
            n = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31);
            start($urandom_range(0, 15), n);
            if (n > 0 && $urandom_range(0, 3) == 0) start($urandom_range(0, 15), $urandom_range(0, 31));
            wait_drain(2000);
            check("rand_pops", run_pop, n);
            check("rand_err", err_overrun, m_err);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
